// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer holding the architected HI/LO pair.
// Optional MDU_MADD_EN enables madd/maddu (mdop 6/7) accumulate into HI/LO.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        intreq,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [2:0]  op_r, op_s;
    logic        first_r, first_s;
    logic        skip_r, skip_s;
    logic [63:0] pend_r, pend_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [63:0] res_s;
    logic [3:0]  load_s;
    logic        legal_s;
    logic        busy_s;
    logic        accept_s;

    // Sign-extending the operands to 64 bits makes the truncated product the signed result.
    function automatic logic [63:0] mul_calc(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {(sgn ? {32{x[31]}} : 32'h0000_0000), x};
        ye = {(sgn ? {32{y[31]}} : 32'h0000_0000), y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}; signed case divides magnitudes and restores signs.
    function automatic logic [63:0] div_calc(input logic [31:0] n, input logic [31:0] d,
                                             input logic sgn);
        logic        neg_q;
        logic        neg_r;
        logic [31:0] un;
        logic [31:0] ud;
        logic [31:0] q;
        logic [31:0] r;
        neg_r = sgn & n[31];
        neg_q = sgn & (n[31] ^ d[31]);
        un    = neg_r ? (32'h0000_0000 - n) : n;
        ud    = (sgn & d[31]) ? (32'h0000_0000 - d) : d;
        q     = (ud == 32'h0000_0000) ? 32'h0000_0000 : (un / ud);
        r     = (ud == 32'h0000_0000) ? 32'h0000_0000 : (un % ud);
        q     = neg_q ? (32'h0000_0000 - q) : q;
        r     = neg_r ? (32'h0000_0000 - r) : r;
        return {r, q};
    endfunction

    // Result and latency for the E-stage operation, evaluated in the accept cycle.
    always_comb begin
        res_s  = 64'h0;
        load_s = 4'd1;
        case (mdop)
            3'd0, 3'd6: begin
                res_s  = mul_calc(a, b, 1'b1);
                load_s = 4'(MULT_CYCLES);
            end
            3'd1, 3'd7: begin
                res_s  = mul_calc(a, b, 1'b0);
                load_s = 4'(MULT_CYCLES);
            end
            3'd2: begin
                res_s  = div_calc(a, b, 1'b1);
                load_s = 4'(DIV_CYCLES);
            end
            3'd3: begin
                res_s  = div_calc(a, b, 1'b0);
                load_s = 4'(DIV_CYCLES);
            end
            3'd4:    res_s = {a, 32'h0000_0000};
            3'd5:    res_s = {32'h0000_0000, a};
            default: res_s = 64'h0;
        endcase
    end

`ifdef MDU_MADD_EN
    assign legal_s = 1'b1;
`else
    assign legal_s = (mdop <= 3'd5);
`endif

    assign busy_s   = (state_r == ST_RUN);
    assign accept_s = start & ~busy_s & ~intreq & legal_s;

    // Next-state, counter and HI/LO commit logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        first_s = first_r;
        skip_s  = skip_r;
        pend_s  = pend_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                    cnt_s   = load_s;
                    op_s    = mdop;
                    first_s = 1'b1;
                    skip_s  = ((mdop == 3'd2) || (mdop == 3'd3)) && (b == 32'h0000_0000);
                    pend_s  = res_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                first_s = 1'b0;
                cnt_s   = cnt_r - 4'd1;
                if (first_r && intreq) begin
                    // Instruction flushed while in M: drop it without touching HI/LO.
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    case (op_r)
                        3'd4: hi_s = pend_r[63:32];
                        3'd5: lo_s = pend_r[31:0];
`ifdef MDU_MADD_EN
                        3'd6, 3'd7: {hi_s, lo_s} = {hi_r, lo_r} + pend_r;
`endif
                        default: begin
                            if (!skip_r) begin
                                {hi_s, lo_s} = pend_r;
                            end else begin
                                {hi_s, lo_s} = {hi_r, lo_r};
                            end
                        end
                    endcase
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, pending result and architected HI/LO registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            op_r    <= 3'd0;
            first_r <= 1'b0;
            skip_r  <= 1'b0;
            pend_r  <= 64'h0;
            hi_r    <= 32'h0000_0000;
            lo_r    <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            first_r <= first_s;
            skip_r  <= skip_s;
            pend_r  <= pend_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

    assign busy  = busy_s;
    assign stall = d_uses_md & (busy_s | accept_s);
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule
